// File: rtl/pipe_stage_buf.sv
// Purpose : DEPTH-stage valid/ready register chain with bubble collapse, flush and occupancy count.
// Latency : DEPTH-1 cycles from input handshake to out_valid on an empty chain; one word per cycle sustained.
// Backpr. : in_ready combinational from chain state, or a flop when PIPE_SKID_EN adds a one-entry input skid.
module pipe_stage_buf #(
    parameter  int WIDTH = 101,             // payload: mem data, ALU result, dest reg, PC+4
    parameter  int DEPTH = 2,               // number of register stages, 1..8
    localparam int CW    = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst,           // asynchronous, active-low
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_dat [DEPTH];
    logic [CW-1:0]    r_occ;

    logic [DEPTH-1:0] w_adv;
    logic             w_src_vld [DEPTH];
    logic [WIDTH-1:0] w_src_dat [DEPTH];
    logic             w_out_go;
    logic             w_s0_free;
    logic             w_s0_load;
    logic [WIDTH-1:0] w_s0_dat;
    logic             w_in_hs;
    logic             w_out_hs;

    // Flush suppresses the output handshake for the cycle it is asserted.
    assign w_out_go = out_ready && !flush;

    // A stage moves on unless it and every stage after it are full and the output is stalled.
    always_comb begin
        logic l_all_full;
        w_adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            l_all_full = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
                l_all_full = l_all_full && r_vld[j];
            end
            w_adv[i] = r_vld[i] && (w_out_go || !l_all_full);
        end
    end

    assign w_s0_free = !r_vld[0] || w_adv[0];

`ifdef PIPE_SKID_EN
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_skid_dat;

    // in_ready only depends on the skid flop (plus reset/flush gating).
    assign in_ready  = rst && !flush && !r_skid_vld;
    assign w_in_hs   = in_valid && in_ready;
    // A parked skid word always has priority into stage 0 so ordering is kept.
    assign w_s0_load = w_s0_free && (r_skid_vld || w_in_hs);
    assign w_s0_dat  = r_skid_vld ? r_skid_dat : in_data;

    // Skid catches an accepted word that stage 0 cannot take this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (flush) begin
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld && w_s0_free) begin
            r_skid_vld <= 1'b0;
        end else if (w_in_hs && !w_s0_free) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= in_data;
        end
    end
`else
    assign in_ready  = rst && !flush && w_s0_free;
    assign w_in_hs   = in_valid && in_ready;
    assign w_s0_load = w_in_hs;
    assign w_s0_dat  = in_data;
`endif

    assign out_valid = r_vld[DEPTH-1] && !flush;
    assign out_data  = r_dat[DEPTH-1];
    assign w_out_hs  = out_valid && out_ready;
    assign occupancy = r_occ;

    // Source of each stage: stage 0 from the input side, others from the stage before.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_src_vld[i] = 1'b0;
            w_src_dat[i] = '0;
        end
        w_src_vld[0] = w_s0_load;
        w_src_dat[0] = w_s0_dat;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_vld[i] = w_adv[i-1];
            w_src_dat[i] = r_dat[i-1];
        end
    end

    // Stage registers: load when the source moves in, empty when the word leaves, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    r_vld[i] <= 1'b0;
                end else if (w_src_vld[i]) begin
                    r_vld[i] <= 1'b1;
                end else if (w_adv[i]) begin
                    r_vld[i] <= 1'b0;
                end
                // Data is never cleared by flush; only the valid bits matter.
                if (w_src_vld[i]) begin
                    r_dat[i] <= w_src_dat[i];
                end
            end
        end
    end

    // Occupancy tracks handshakes: in adds, out subtracts, both cancel, flush zeroes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_hs && !w_out_hs) begin
            r_occ <= r_occ + CW'(1);
        end else if (!w_in_hs && w_out_hs) begin
            r_occ <= r_occ - CW'(1);
        end
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 101, payload bits per stage (32 mem data + 32 ALU result + 5 dest reg + 32 PC+4).
REQ-002 Parameter DEPTH, default 2, number of register stages, legal range 1..8.
REQ-003 Derived CW = $clog2(DEPTH+2), occupancy counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline flush, active-high.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  WIDTH  payload of last stage.
REQ-013 occupancy  output  CW  registered count of valid words held.

Function
REQ-014 Stages 0..DEPTH-1 each hold valid bit + WIDTH data; stage 0 fed by input, stage DEPTH-1 drives out_valid/out_data.
REQ-015 Stage i advances when valid[i] && (i==DEPTH-1 ? out_ready : (!valid[i+1] || advance[i+1])); bubbles collapse, no slot left empty behind a stalled word.
REQ-016 Stage i loads from its source when its source is valid and advancing (stage 0: in_valid && in_ready); otherwise valid[i] cleared if advancing, held if stalled.
REQ-017 Stalled stage holds data bit-exact; out_data stable while out_valid && !out_ready.
REQ-018 Without skid, in_ready = !valid[0] || advance[0] (combinational).
REQ-019 Latency, empty chain, out_ready=1: word accepted at edge N is on out_data after edge N+DEPTH-1 (out_valid during cycle N+DEPTH-1); throughput one word/cycle sustained.
REQ-020 Order preserved; no word duplicated or dropped except by flush.
REQ-021 flush=1: in_ready=0, out_valid=0 that cycle; at next edge all valid bits (and skid) cleared, occupancy=0; data registers not cleared.
REQ-022 flush overrides any simultaneous input or output handshake; neither completes.
REQ-023 occupancy updated each edge: +1 on input handshake, -1 on output handshake, both => unchanged; flush => 0.

Reset
REQ-024 rst low asynchronously clears all valid bits, all data registers to 0, skid to empty, occupancy to 0.
REQ-025 During reset: out_valid=0, out_data=0, in_ready=0.
REQ-026 First cycle after rst deasserts: in_ready=1; reset mid-transfer discards all held words with no partial output.

Configuration
REQ-027 Macro PIPE_SKID_EN, when defined, adds one-entry input skid register making in_ready a pure flop output: in_ready = !skid_valid.
REQ-028 With PIPE_SKID_EN: accepted word goes to stage 0 if stage 0 can load, else to skid; skid drains into stage 0 with priority over in_data; occupancy counts skid; max occupancy DEPTH+1.
REQ-029 With PIPE_SKID_EN: latency with empty skid identical to REQ-019.
REQ-030 Without PIPE_SKID_EN: no skid logic, in_ready per REQ-018, max occupancy DEPTH.

Verification
REQ-031 DEPTH=2, out_ready=1, in_data=1,2,3 on consecutive cycles -> out_data 1,2,3 consecutive from cycle 1 after first accept, occupancy never >2.
REQ-032 DEPTH=2, fill with 0xA,0xB, out_ready=0 -> in_ready=0, occupancy=2, out_data=0xA held; out_ready=1 one cycle -> out_data=0xB next.
REQ-033 DEPTH=3, word 0x5 at stage 0 only, out_ready=0 -> word collapses to stage 2 in 2 cycles, occupancy=1.
REQ-034 DEPTH=2 full, flush=1 with in_valid=1 in_data=0x7 -> next cycle out_valid=0, occupancy=0, 0x7 never appears.
REQ-035 PIPE_SKID_EN, DEPTH=2 full, out_ready=0, in_valid=1 in_data=0x9 -> skid holds 0x9, in_ready=0 next cycle, occupancy=3; release -> outputs in order ending 0x9.
REQ-036 rst pulsed low mid-stream asynchronously -> out_valid=0, occupancy=0 immediately, no stale word after release.
